// File: rtl/reg_bank32.sv
// Register bank feeding the ALU: two combinational read ports with write-through
// bypass, one synchronous write port, and registered carry/zero status flags.
module reg_bank32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flag_we,
  input  logic              iCarry,
  input  logic              iZero,
  output logic              oFlagC,
  output logic              oFlagZ
);

  localparam int DEPTH = 2 ** ADDR_W;

  // r0 has no storage; its reads are forced to zero below.
  logic [DATA_W-1:0] regs [1:DEPTH-1];
  logic              wr_ok;

  assign wr_ok = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oFlagC <= 1'b0;
      oFlagZ <= 1'b0;
    end else if (flag_we) begin
      oFlagC <= iCarry;
      oFlagZ <= iZero;
    end
  end

  // Bypass is not gated by reset, so a same-cycle write still shows while rst_n is low.
  always_comb begin
    rdata1 = '0;
    if (raddr1 != '0) begin
      if (wr_ok && (waddr == raddr1)) rdata1 = wdata;
      else                            rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != '0) begin
      if (wr_ok && (waddr == raddr2)) rdata2 = wdata;
      else                            rdata2 = regs[raddr2];
    end
  end

endmodule
